// File: rtl/mips_pkg.sv
// Shared MIPS constants, fetch-slot state encoding and instruction-field helpers.
package mips_pkg;

    localparam logic [5:0]  OPC_J       = 6'b000010;
    localparam logic [5:0]  OPC_BEQ     = 6'b000100;
    localparam logic [5:0]  OPC_ADDI    = 6'b001000;
    localparam int unsigned INSTR_BYTES = 4;

    // Occupancy of the fetch/decode slot.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // Major opcode field of an instruction word.
    function automatic logic [5:0] opcode(input logic [31:0] word);
        return word[31:26];
    endfunction

    // Jump target: the 26-bit field is a byte address; the upper PC bits are kept.
    function automatic logic [31:0] jtarget(input logic [31:0] pc, input logic [31:0] word);
        return {pc[31:26], word[25:0]};
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection: sequential pc+4, or a predecoded j target.
module fetch_pc_next
    import mips_pkg::*;
#(
    parameter bit JUMP_PREDECODE = 1'b1
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] next_pc_c_o,
    output logic        is_jump_c_o
);

    // Redirect locally on j only when predecode is enabled; pc+4 wraps modulo 2^32.
    always_comb begin
        is_jump_c_o = JUMP_PREDECODE && (opcode(imem_data_i) == OPC_J);
        next_pc_c_o = is_jump_c_o ? jtarget(pc_i, imem_data_i)
                                  : pc_i + 32'(INSTR_BYTES);
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, captures instruction memory into the decode slot,
// honours execute-stage redirects and counts stalled cycles.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          JUMP_PREDECODE = 1'b1,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_data,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   fetch_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    slot_state_e            state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            instr_q, instr_d;
    logic [31:0]            instr_pc_q, instr_pc_d;
    logic                   fetch_err_q, fetch_err_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [31:0]            next_pc_c;
    logic                   is_jump_unused;
    logic                   adv_c;

    fetch_pc_next #(
        .JUMP_PREDECODE (JUMP_PREDECODE)
    ) u_pc_next (
        .pc_i        (pc_q),
        .imem_data_i (imem_data),
        .next_pc_c_o (next_pc_c),
        .is_jump_c_o (is_jump_unused)
    );

    // The slot may take a new word when it is empty or decode drains it this cycle.
    assign adv_c = (state_q == ST_EMPTY) || instr_ready;

    // Next-state: redirect beats capture beats stall.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        fetch_err_d = fetch_err_q;
        stall_cnt_d = stall_cnt_q;

        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = ST_EMPTY;
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_err_d = 1'b1;
            end
        end else if (adv_c) begin
            instr_d    = imem_data;
            instr_pc_d = pc_q;
            pc_d       = next_pc_c;
            state_d    = ST_FULL;
        end else if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            instr_pc_q  <= 32'h0;
            fetch_err_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            fetch_err_q <= fetch_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == ST_FULL);
    assign fetch_err   = fetch_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the MIPS_Cpu core. Owns the program counter and drives the address to the combinational instruction memory.
- Captures the returned word into a registered fetch/decode slot, using a valid/ready handshake toward decode.
- Resolves unconditional jumps (opcode 000010) locally by predecode.
- Accepts late redirects, such as taken beq, from execute and flushes the slot when one arrives.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- JUMP_PREDECODE, 1, when 1 the fetch stage redirects on j itself; when 0 the next PC is always pc+4.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_addr  out  32  instruction memory address; always equals pc (combinational)
- imem_data  in  32  instruction word returned combinationally for imem_addr
- instr  out  32  registered instruction to decode
- instr_pc  out  32  byte address of instr
- instr_valid  out  1  slot holds a valid instruction
- instr_ready  in  1  decode accepts the slot this cycle
- redirect_valid  in  1  execute-stage redirect (taken branch)
- redirect_pc  in  32  redirect target byte address
- fetch_err  out  1  sticky flag: a misaligned redirect was received
- stall_cnt  out  STALL_CNT_W  count of held cycles (saturating)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_err=0, stall_cnt=0. Reset overrides all other inputs in the same cycle.
- Advance condition: adv = !instr_valid || instr_ready.
- Per-cycle priority, highest first:
  1. redirect_valid:
     - pc <= {redirect_pc[31:2],2'b00}; instr_valid <= 0 (flush).
     - No capture this cycle.
     - If redirect_pc[1:0]!=0, fetch_err <= 1.
  2. adv:
     - instr <= imem_data; instr_pc <= pc; instr_valid <= 1; pc <= next_pc.
  3. else (stall):
     - pc, instr, instr_pc and instr_valid are held.
     - stall_cnt <= stall_cnt+1, saturating at all-ones.
- next_pc:
  - If JUMP_PREDECODE and imem_data[31:26]==6'b000010: next_pc = {pc[31:26], imem_data[25:0]}. The target field is a byte address; the upper pc bits are kept.
  - Otherwise next_pc = pc + 32'd4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x0).
- The j word itself is still delivered to decode; decode treats it as a no-op.
- Branch convention for the execute redirect source: target = branch instr_pc + sign_extend(imm16), where imm16 is a byte offset. This block only consumes redirect_pc.
- Latency:
  - The first valid instruction appears the cycle after reset deasserts.
  - After a redirect, the target instruction is valid exactly 2 cycles after the cycle in which redirect_valid was sampled: one flush cycle, then capture.
  - Throughput is 1 instruction per cycle while instr_ready=1.
- Simultaneous events:
  - redirect_valid with instr_ready=0: the redirect wins and the slot is flushed. stall_cnt does not increment.
  - redirect_valid in the same cycle as a predecoded j: the redirect wins.
- Back-to-back redirects: the last one sampled wins.
- Reset mid-stall or mid-flush returns to the reset values; no residual instruction is visible.
- fetch_err clears only on reset.
- An all-zero word from unmapped memory is captured like any other instruction (sll $0 no-op).
- Control is a two-state FSM on instr_valid: EMPTY <-> FULL.
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on redirect, or on instr_ready with no capture. No capture can occur only during a redirect, so in practice FULL stays FULL while advancing.

Decomposition:
- Shared package mips_pkg holds:
  - constants OPC_J=6'b000010, OPC_BEQ=6'b000100, OPC_ADDI=6'b001000, INSTR_BYTES=4;
  - helper functions opcode(), jtarget().
- One natural sub-module: fetch_pc_next. It is combinational next-PC selection: pc, imem_data -> next_pc, is_jump.
- The slot, FSM, counters and error flag remain in instr_fetch.

Test Plan:
1. Reset then release, instr_ready=1, linear memory image: instr_pc sequence 0x0,0x4,0x8,… with instr_valid high from the first cycle after release. Reset held mid-run returns all outputs to 0.
2. j with field 4 at 0x24 (word 0x08000004): the next captured instr_pc is 0x04, not 0x28, with no bubble. With JUMP_PREDECODE=0 the next captured instr_pc is 0x28.
3. redirect_valid with redirect_pc=0x20 while the slot holds 0x08: the next cycle has instr_valid=0, and the cycle after has instr_pc=0x20.
4. instr_ready=0 for 5 cycles with the slot full: instr and pc are stable and stall_cnt=5. A redirect during the stall flushes the slot and stall_cnt stays 5.
5. redirect_pc=0x13: pc becomes 0x10, fetch_err=1 and stays 1 until reset.
6. pc reaches 0xFFFFFFFC with a non-jump word: the next instr_pc is 0x00000000. Saturation check with STALL_CNT_W=4: 20 stall cycles -> stall_cnt=0xF.
